// File: rtl/drum_pkg.sv
// Shared drum-voice constants: voice indices, sample windows, default widths
// and the read-tag layout carried alongside each ROM read.
package drum_pkg;

    localparam int unsigned VOICE_KICK  = 0;
    localparam int unsigned VOICE_SNARE = 1;
    localparam int unsigned VOICE_HAT   = 2;
    localparam int unsigned VOICE_CLAP  = 3;

    localparam int unsigned DEFAULT_NUM_VOICES = 4;
    localparam int unsigned DEFAULT_ADDR_W     = 16;
    localparam int unsigned DEFAULT_DATA_W     = 16;
    localparam int unsigned DEFAULT_ROM_LAT    = 1;

    localparam int unsigned KICK_BASE_ADDR  = 0;
    localparam int unsigned KICK_SAMPLE_LEN = 4096;
    localparam int unsigned SNARE_BASE_ADDR  = 4096;
    localparam int unsigned SNARE_SAMPLE_LEN = 4096;
    localparam int unsigned HAT_BASE_ADDR  = 8192;
    localparam int unsigned HAT_SAMPLE_LEN = 2048;
    localparam int unsigned CLAP_BASE_ADDR  = 10240;
    localparam int unsigned CLAP_SAMPLE_LEN = 4096;

    localparam int unsigned TAG_IDX_W = $clog2(DEFAULT_NUM_VOICES);
    localparam int unsigned TAG_W     = 1 + TAG_IDX_W;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/sample_rom_arbiter_if.sv
// Voice-side and ROM-side signals of the sample ROM arbiter. The master side
// is the environment (voices plus ROM); the slave side is the arbiter.
interface sample_rom_arbiter_if #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16
);
    logic [NUM_VOICES-1:0]        req;
    logic [NUM_VOICES*ADDR_W-1:0] req_addr;
    logic [NUM_VOICES-1:0]        gnt;
    logic [NUM_VOICES-1:0]        rd_valid;
    logic [DATA_W-1:0]            rd_data;
    logic                         rom_en;
    logic [ADDR_W-1:0]            rom_addr;
    logic [DATA_W-1:0]            rom_data;

    modport master (
        output req, req_addr, rom_data,
        input  gnt, rd_valid, rd_data, rom_en, rom_addr
    );

    modport slave (
        input  req, req_addr, rom_data,
        output gnt, rd_valid, rd_data, rom_en, rom_addr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above ptr, with
// wrap, yields a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic [NUM_VOICES-1:0]         req,
    input  logic [$clog2(NUM_VOICES)-1:0] ptr,
    output logic [NUM_VOICES-1:0]         gnt,
    output logic [$clog2(NUM_VOICES)-1:0] winner
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt    = '0;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned off = 0; off < NUM_VOICES; off++) begin
            // explicit wrap keeps non-power-of-2 voice counts in range
            idx = 32'(ptr) + off;
            if (idx >= NUM_VOICES) begin
                idx = idx - NUM_VOICES;
            end
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                winner   = IDX_W'(idx);
            end
        end
    end
endmodule

// File: rtl/sample_rom_arbiter.sv
// Shares one synchronous sample ROM among the drum voices: round-robin issue,
// one read per clk, data routed back through a fixed-depth tag pipeline.
module sample_rom_arbiter
    import drum_pkg::*;
#(
    parameter int unsigned NUM_VOICES = DEFAULT_NUM_VOICES,
    parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W     = DEFAULT_DATA_W,
    parameter int unsigned ROM_LAT    = DEFAULT_ROM_LAT
) (
    input  logic                 clk,
    input  logic                 rst,
    sample_rom_arbiter_if.slave  bus,
    output logic                 busy
);
    localparam int unsigned IDX_W = $clog2(NUM_VOICES);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } stage_t;

    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      winner;
    logic [NUM_VOICES-1:0] arb_gnt;
    logic                  grant;
    logic [ADDR_W-1:0]     win_addr;
    logic [ADDR_W-1:0]     rom_addr_q;
    logic                  rom_en_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic [NUM_VOICES-1:0] rd_valid_q;
    stage_t                tag_q [ROM_LAT+1];

    rr_arbiter #(
        .NUM_VOICES(NUM_VOICES)
    ) u_rr_arbiter (
        .req    (bus.req),
        .ptr    (ptr),
        .gnt    (arb_gnt),
        .winner (winner)
    );

    assign bus.gnt      = rst ? '0 : arb_gnt;
    assign grant        = |bus.gnt;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

    always_comb begin
        win_addr = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (arb_gnt[i]) begin
                win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i <= ROM_LAT; i++) begin
            busy = busy | tag_q[i].valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= '0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            for (int unsigned i = 0; i <= ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            rom_en_q <= grant;
            if (grant) begin
                rom_addr_q <= win_addr;
                ptr        <= (winner == IDX_W'(NUM_VOICES - 1)) ? '0 : winner + IDX_W'(1);
            end
            tag_q[0] <= '{valid: grant, idx: winner};
            for (int unsigned i = 1; i <= ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            // last stage lines up with rom_data for the read it tags
            if (tag_q[ROM_LAT].valid) begin
                rd_data_q  <= bus.rom_data;
                rd_valid_q <= NUM_VOICES'(1) << tag_q[ROM_LAT].idx;
            end else begin
                rd_valid_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_sample_rom_arbiter.sv
// Self-checking bench: a default 4-voice/ROM_LAT=1 arbiter and a 3-voice/ROM_LAT=3
// arbiter checked cycle by cycle against a round-robin/scoreboard reference.
module tb_sample_rom_arbiter;
    import drum_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy0, busy1;

    always #5 clk = ~clk;

    sample_rom_arbiter_if #(.NUM_VOICES(4), .ADDR_W(16), .DATA_W(16)) bus0 ();
    sample_rom_arbiter_if #(.NUM_VOICES(3), .ADDR_W(16), .DATA_W(16)) bus1 ();

    sample_rom_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus0),
        .busy (busy0)
    );

    sample_rom_arbiter #(
        .NUM_VOICES(3),
        .ADDR_W    (16),
        .DATA_W    (16),
        .ROM_LAT   (3)
    ) dut3 (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus1),
        .busy (busy1)
    );

    logic [3:0]  req_v  [2];
    logic [15:0] addr_v [2][4];

    assign bus0.req      = req_v[0];
    assign bus0.req_addr = {addr_v[0][3], addr_v[0][2], addr_v[0][1], addr_v[0][0]};
    assign bus1.req      = req_v[1][2:0];
    assign bus1.req_addr = {addr_v[1][2], addr_v[1][1], addr_v[1][0]};

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // ROM models: address captured on each edge, word appears ROM_LAT clks later
    logic [15:0] rp0 [1];
    logic [15:0] rp1 [3];
    always @(posedge clk) begin
        rp0[0] <= bus0.rom_addr;
        rp1[0] <= bus1.rom_addr;
        rp1[1] <= rp1[0];
        rp1[2] <= rp1[1];
    end
    assign bus0.rom_data = rom_word(rp0[0]);
    assign bus1.rom_data = rom_word(rp1[2]);

    typedef struct {
        int          d;
        int          voice;
        logic [15:0] addr;
        int          due;
    } sb_t;

    sb_t         sb [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mptr     [2];
    int          last_en  [2];
    logic [15:0] last_addr[2];
    logic [31:0] gnt_seen [2];
    int          pulses   [2];
    int          wait_cnt [2][4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int nv_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // One clock: compare every output of both DUTs against the reference at
    // the falling edge, update the reference, then advance past the rising edge.
    task automatic tick();
        logic [31:0] g, rv, rdd, re, ra, bz, exp_g, exp_rv;
        int          nv, lat, w, idx, v, pend;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            nv  = nv_of(d);
            lat = lat_of(d);
            if (d == 0) begin
                g = 32'(bus0.gnt); rv = 32'(bus0.rd_valid); rdd = 32'(bus0.rd_data);
                re = 32'(bus0.rom_en); ra = 32'(bus0.rom_addr); bz = 32'(busy0);
            end else begin
                g = 32'(bus1.gnt); rv = 32'(bus1.rd_valid); rdd = 32'(bus1.rd_data);
                re = 32'(bus1.rom_en); ra = 32'(bus1.rom_addr); bz = 32'(busy1);
            end
            if (rv != 0) pulses[d]++;
            if (rst) begin
                check_eq("rst_gnt", g, 0);
                check_eq("rst_rd_valid", rv, 0);
                check_eq("rst_rd_data", rdd, 0);
                check_eq("rst_rom_en", re, 0);
                check_eq("rst_rom_addr", ra, 0);
                check_eq("rst_busy", bz, 0);
                sb.delete();
                mptr[d]     = 0;
                last_en[d]  = 0;
                gnt_seen[d] = 0;
                for (int k = 0; k < 4; k++) wait_cnt[d][k] = 0;
            end else begin
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].d == d) idx = i;
                exp_rv = 0;
                if (idx >= 0 && sb[idx].due == cyc) begin
                    exp_rv = 32'(1) << sb[idx].voice;
                    check_eq("rd_data", rdd, 32'(rom_word(sb[idx].addr)));
                    sb.delete(idx);
                end
                check_eq("rd_valid", rv, exp_rv);
                pend = 0;
                for (int i = 0; i < sb.size(); i++)
                    if (sb[i].d == d) pend = 1;
                check_eq("busy", bz, 32'(pend));
                check_eq("rom_en", re, 32'(last_en[d]));
                if (last_en[d] != 0) check_eq("rom_addr", ra, 32'(last_addr[d]));
                w = -1;
                for (int k = 0; k < nv; k++) begin
                    v = (mptr[d] + k) % nv;
                    if (w < 0 && req_v[d][v]) w = v;
                end
                exp_g = (w < 0) ? 32'd0 : (32'(1) << w);
                check_eq("gnt", g, exp_g);
                for (int k = 0; k < nv; k++) begin
                    if (req_v[d][k]) begin
                        wait_cnt[d][k]++;
                        if (g[k]) begin
                            check_eq("fair_wait", 32'(wait_cnt[d][k] <= nv), 1);
                            wait_cnt[d][k] = 0;
                        end
                    end else begin
                        wait_cnt[d][k] = 0;
                    end
                end
                if (w >= 0) begin
                    sb.push_back('{d: d, voice: w, addr: addr_v[d][w], due: cyc + lat + 2});
                    mptr[d]      = (w + 1) % nv;
                    last_en[d]   = 1;
                    last_addr[d] = addr_v[d][w];
                end else begin
                    last_en[d] = 0;
                end
                gnt_seen[d] = g;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    int p;
    int left;
    logic [3:0] seq_exp;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_v[d]  = '0;
            mptr[d]   = 0;
            last_en[d] = 0;
            pulses[d] = 0;
            gnt_seen[d] = 0;
            for (int k = 0; k < 4; k++) begin
                addr_v[d][k]   = '0;
                wait_cnt[d][k] = 0;
            end
        end

        // reset with all voices requesting, then round-robin from voice 0
        req_v[0] = 4'b1111;
        for (int k = 0; k < 4; k++) addr_v[0][k] = 16'(k * 16'h0100);
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            seq_exp = 4'b0001 << (k % 4);
            check_eq("rr_sequence", gnt_seen[0], 32'(seq_exp));
        end
        req_v[0] = '0;
        repeat (4) tick();

        // single snare voice streaming three consecutive words
        p = pulses[0];
        for (int k = 0; k < 3; k++) begin
            req_v[0] = 4'b0010;
            addr_v[0][VOICE_SNARE] = 16'(SNARE_BASE_ADDR + k);
            tick();
            check_eq("snare_gnt", gnt_seen[0], 32'b0010);
        end
        req_v[0] = '0;
        repeat (4) tick();
        check_eq("snare_pulses", 32'(pulses[0] - p), 3);

        // reset right after a grant discards the read
        req_v[0] = 4'b0100;
        addr_v[0][VOICE_HAT] = 16'(HAT_BASE_ADDR);
        tick();
        check_eq("hat_gnt", gnt_seen[0], 32'b0100);
        req_v[0] = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        p = pulses[0];
        repeat (9) tick();
        check_eq("rst_discard", 32'(pulses[0] - p), 0);
        req_v[0] = 4'b0100;
        addr_v[0][VOICE_HAT] = 16'(HAT_BASE_ADDR + 7);
        tick();
        req_v[0] = '0;
        p = pulses[0];
        repeat (4) tick();
        check_eq("rst_regrant", 32'(pulses[0] - p), 1);

        // pointer-relative priority and an abandoned request
        req_v[0] = 4'b0001;
        addr_v[0][VOICE_KICK] = 16'(KICK_BASE_ADDR + 3);
        tick();
        req_v[0] = 4'b0101;
        addr_v[0][VOICE_HAT] = 16'(HAT_BASE_ADDR + 9);
        tick();
        check_eq("ptr1_gnt", gnt_seen[0], 32'b0100);
        req_v[0] = 4'b0001;
        tick();
        check_eq("wrap_gnt", gnt_seen[0], 32'b0001);
        req_v[0] = 4'b0110;
        addr_v[0][VOICE_SNARE] = 16'(SNARE_BASE_ADDR + 100);
        addr_v[0][VOICE_HAT]   = 16'(HAT_BASE_ADDR + 100);
        tick();
        check_eq("contend_gnt", gnt_seen[0], 32'b0010);
        req_v[0] = '0;
        tick();
        check_eq("withdraw_gnt", gnt_seen[0], 0);
        repeat (5) tick();

        // randomized traffic on both configurations
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < nv_of(d); k++) begin
                    if (gnt_seen[d][k]) begin
                        req_v[d][k]  = 1'($urandom_range(0, 1));
                        addr_v[d][k] = 16'($urandom);
                    end else if (req_v[d][k]) begin
                        if ($urandom_range(0, 31) == 0) req_v[d][k] = 1'b0;
                    end else if ($urandom_range(0, 3) != 0) begin
                        req_v[d][k]  = 1'b1;
                        addr_v[d][k] = 16'($urandom);
                    end
                end
            end
            tick();
        end
        req_v[0] = '0;
        req_v[1] = '0;
        repeat (8) tick();
        for (int d = 0; d < 2; d++) begin
            left = 0;
            for (int i = 0; i < sb.size(); i++)
                if (sb[i].d == d) left++;
            check_eq("scoreboard_empty", 32'(left), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
